ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: data word width.
REQ-002 Parameter ADDR_W, default 10: address width.
REQ-003 Parameter MEM_DEPTH, default 11: number of implemented data RAM words.
REQ-004 Parameter STARVE_MAX, default 4: consecutive IO losses before IO gets forced priority.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clock  in  1  system clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 cpu_req  in  1  CPU requests one access.
REQ-009 cpu_write  in  1  1 = write, 0 = read.
REQ-010 cpu_addr  in  ADDR_W  CPU word address.
REQ-011 cpu_wdata  in  DATA_W  CPU write data.
REQ-012 cpu_gnt  out  1  CPU request accepted this cycle.
REQ-013 cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid.
REQ-014 cpu_rdata  out  DATA_W  CPU read data.
REQ-015 io_req, io_write, io_addr, io_wdata, io_gnt, io_rvalid, io_rdata: IO-agent port (button mirror, display fetch), same widths and meaning as the CPU port.
REQ-016 mem_write  out  1  RAM write strobe.
REQ-017 mem_addr  out  ADDR_W  RAM address.
REQ-018 mem_value  out  DATA_W  RAM write data.
REQ-019 mem_result  in  DATA_W  RAM combinational read data.
REQ-020 addr_err  out  1  one-cycle pulse on an out-of-range access.

Function
REQ-021 FSM states: IDLE, ACCESS; reset state IDLE.
REQ-022 In IDLE, gnt is combinational: exactly one of cpu_gnt/io_gnt goes high when the corresponding req is high; both are low in ACCESS.
REQ-023 Transfer occurs at the rising edge where req && gnt; the winner's write/addr/wdata and an owner flag are latched, and the FSM enters ACCESS.
REQ-024 Priority: CPU wins when both request, unless starve_cnt == STARVE_MAX; then IO wins.
REQ-025 starve_cnt increments (saturating at STARVE_MAX) on each transfer granted to the CPU while io_req is high; clears on an IO transfer or when io_req is low in IDLE.
REQ-026 ACCESS lasts exactly one cycle; mem_addr/mem_value are driven from the latched registers; mem_write = latched write && in-range.
REQ-027 In-range means addr < MEM_DEPTH; out-of-range write: mem_write stays 0.
REQ-028 Read: at the edge ending ACCESS, the owner's rdata <= mem_result (0 if out-of-range) and the owner's rvalid pulses high for one cycle; the other port's rvalid stays 0.
REQ-029 Write: no rvalid.
REQ-030 addr_err pulses one cycle, aligned with the would-be rvalid slot, for any out-of-range access.
REQ-031 After ACCESS, the FSM returns to IDLE; the peak rate is one access per 2 cycles; the next grant may coincide with the previous rvalid.
REQ-032 The requester holds req and its command stable until gnt; after a transfer it may drop req or present a new command.
REQ-033 rdata holds its last value until the owner's next read completes.
REQ-034 mem_write is never high outside ACCESS.

Reset
REQ-035 On reset: state IDLE; starve_cnt 0; all gnt, rvalid, mem_write, and addr_err outputs 0; mem_addr, mem_value, and rdata 0.
REQ-036 Reset asserted during ACCESS aborts the access: no rvalid, and mem_write is 0 from the next cycle on.

Structure
REQ-037 Package ram_arb_pkg holds the state enum {IDLE, ACCESS} and the default constants DATA_W, ADDR_W, MEM_DEPTH, STARVE_MAX.
REQ-038 One sub-module, arb_starve_ctr, holds the saturating starvation counter and the force_io output.
REQ-039 There is no combinational path from mem_result to any output; rdata is registered.

Verification
REQ-040 CPU read addr 0, mem_result=32'h5 -> cpu_gnt at edge E0, mem_addr=0 during ACCESS, cpu_rvalid=1 and cpu_rdata=5 in the cycle after E1.
REQ-041 IO write addr 1, data 1 -> io_gnt, then mem_write=1 with mem_addr=1 and mem_value=1 for exactly one cycle, then no io_rvalid.
REQ-042 cpu_req and io_req held high continuously, STARVE_MAX=4 -> grant order CPU,CPU,CPU,CPU,IO, then repeat.
REQ-043 CPU write addr 11 (MEM_DEPTH=11) -> mem_write stays 0 and addr_err pulses once; read addr 11 -> cpu_rdata=0, cpu_rvalid=1, addr_err=1.
REQ-044 reset pulsed during the ACCESS of a CPU read -> no cpu_rvalid, all outputs 0, FSM accepts a new request the cycle after reset deasserts.
REQ-045 Back-to-back CPU reads addr 2 then addr 3 -> second cpu_gnt coincides with the first cpu_rvalid; rvalids arrive 2 cycles apart.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default constants for the two-port RAM arbiter.
package ram_arb_pkg;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 10;
  localparam int MEM_DEPTH  = 11;
  localparam int STARVE_MAX = 4;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} arb_state_e;
endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive CPU wins while IO is waiting; raises o_force_io at the limit.
module arb_starve_ctr
  import ram_arb_pkg::*;
#(
  parameter int STARVE_MAX = ram_arb_pkg::STARVE_MAX
) (
  input  logic clock,
  input  logic reset,
  input  logic i_idle,
  input  logic i_io_req,
  input  logic i_cpu_xfer,
  input  logic i_io_xfer,
  output logic o_force_io
);
  localparam int              CW     = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]   LP_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset)
      r_cnt <= '0;
    else if (i_io_xfer || (i_idle && !i_io_req))
      r_cnt <= '0;
    else if (i_cpu_xfer && i_io_req && (r_cnt != LP_MAX))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_force_io = (r_cnt == LP_MAX);
endmodule

// File: rtl/ram_arbiter.sv
// Two-port (CPU / IO) arbiter in front of a single-port RAM: grant in IDLE,
// one ACCESS cycle, registered read data and an out-of-range error pulse.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W     = ram_arb_pkg::DATA_W,
  parameter int ADDR_W     = ram_arb_pkg::ADDR_W,
  parameter int MEM_DEPTH  = ram_arb_pkg::MEM_DEPTH,
  parameter int STARVE_MAX = ram_arb_pkg::STARVE_MAX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_write,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_value,
  input  logic [DATA_W-1:0] mem_result,
  output logic              addr_err
);
  localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(MEM_DEPTH);

  arb_state_e        r_state;
  logic              r_write;
  logic              r_owner_io;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_cpu_rvalid;
  logic              r_io_rvalid;
  logic              r_addr_err;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_io_rdata;

  logic w_idle, w_force_io, w_io_wins, w_cpu_gnt, w_io_gnt, w_in_range;

  assign w_idle     = (r_state == IDLE);
  assign w_io_wins  = io_req && (!cpu_req || w_force_io);
  assign w_cpu_gnt  = w_idle && cpu_req && !w_io_wins;
  assign w_io_gnt   = w_idle && w_io_wins;
  assign w_in_range = (r_addr < LP_DEPTH);

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clock      (clock),
    .reset      (reset),
    .i_idle     (w_idle),
    .i_io_req   (io_req),
    .i_cpu_xfer (w_cpu_gnt),
    .i_io_xfer  (w_io_gnt),
    .o_force_io (w_force_io)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_write      <= 1'b0;
      r_owner_io   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cpu_rvalid <= 1'b0;
      r_io_rvalid  <= 1'b0;
      r_addr_err   <= 1'b0;
      r_cpu_rdata  <= '0;
      r_io_rdata   <= '0;
    end else begin
      r_cpu_rvalid <= 1'b0;
      r_io_rvalid  <= 1'b0;
      r_addr_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cpu_gnt || w_io_gnt) begin
            r_state    <= ACCESS;
            r_owner_io <= w_io_gnt;
            r_write    <= w_io_gnt ? io_write : cpu_write;
            r_addr     <= w_io_gnt ? io_addr  : cpu_addr;
            r_wdata    <= w_io_gnt ? io_wdata : cpu_wdata;
          end
        end
        ACCESS: begin
          r_state    <= IDLE;
          r_addr_err <= !w_in_range;
          // Out-of-range reads still complete, returning zero.
          if (!r_write) begin
            if (r_owner_io) begin
              r_io_rvalid <= 1'b1;
              r_io_rdata  <= w_in_range ? mem_result : '0;
            end else begin
              r_cpu_rvalid <= 1'b1;
              r_cpu_rdata  <= w_in_range ? mem_result : '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign io_gnt     = w_io_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign io_rvalid  = r_io_rvalid;
  assign cpu_rdata  = r_cpu_rdata;
  assign io_rdata   = r_io_rdata;
  assign addr_err   = r_addr_err;
  assign mem_addr   = r_addr;
  assign mem_value  = r_wdata;
  assign mem_write  = (r_state == ACCESS) && r_write && w_in_range;
endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter against a transaction-level reference model.
module tb_ram_arbiter;
  localparam int DW = 32, AW = 10, DEPTH = 11, SMAX = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_write, io_req, io_write;
  logic [AW-1:0] cpu_addr, io_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, io_wdata, cpu_rdata, io_rdata, mem_value, mem_result;
  logic          cpu_gnt, cpu_rvalid, io_gnt, io_rvalid, mem_write, addr_err;

  ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_write(io_write), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_value(mem_value),
    .mem_result(mem_result), .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  // Environment RAM: full address space populated so out-of-range reads must be masked.
  logic [DW-1:0] ram [0:1023];
  assign mem_result = ram[mem_addr];
  always @(posedge clock) if (mem_write) ram[mem_addr] <= mem_value;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  typedef struct packed {
    logic          v;
    logic          wr;
    logic          io;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } acc_t;

  // Reference model state
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  acc_t          acc, done;
  logic [DW-1:0] done_val, exp_crd, exp_ird;
  int            starve;
  // Requester agents
  logic          c_req, c_w, i_req, i_w;
  logic [AW-1:0] c_a, i_a;
  logic [DW-1:0] c_d, i_d;

  task automatic new_cmd(output logic w, output logic [AW-1:0] a, output logic [DW-1:0] d);
    w = 1'($urandom_range(0, 1));
    a = AW'($urandom_range(0, 15));
    d = $urandom;
  endtask

  task automatic model_clear();
    acc = '0; done = '0; done_val = '0;
    exp_crd = '0; exp_ird = '0; starve = 0;
    c_req = 1'b0; i_req = 1'b0;
  endtask

  task automatic drive();
    cpu_req = c_req; cpu_write = c_w; cpu_addr = c_a; cpu_wdata = c_d;
    io_req  = i_req; io_write  = i_w; io_addr  = i_a; io_wdata  = i_d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_gnt"}, cpu_gnt, 0);     chk({tag, "_io_gnt"}, io_gnt, 0);
    chk({tag, "_cpu_rvalid"}, cpu_rvalid, 0); chk({tag, "_io_rvalid"}, io_rvalid, 0);
    chk({tag, "_mem_write"}, mem_write, 0); chk({tag, "_addr_err"}, addr_err, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);   chk({tag, "_mem_value"}, mem_value, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0); chk({tag, "_io_rdata"}, io_rdata, 0);
  endtask

  // One clock cycle. mode 0: random traffic, 1: both always requesting, 2: no new requests.
  task automatic step(input int mode);
    logic io_win, e_cg, e_ig, e_rd;
    @(negedge clock);
    drive();
    #1;
    io_win = i_req && (!c_req || starve == SMAX);
    e_cg   = !acc.v && c_req && !io_win;
    e_ig   = !acc.v && io_win;
    chk("cpu_gnt", cpu_gnt, e_cg);
    chk("io_gnt", io_gnt, e_ig);
    chk("mem_write", mem_write, acc.v && acc.wr && (acc.a < DEPTH));
    if (acc.v) begin
      chk("mem_addr", mem_addr, acc.a);
      chk("mem_value", mem_value, acc.d);
    end
    e_rd = done.v && !done.wr;
    chk("cpu_rvalid", cpu_rvalid, e_rd && !done.io);
    chk("io_rvalid", io_rvalid, e_rd && done.io);
    chk("addr_err", addr_err, done.v && (done.a >= DEPTH));
    if (e_rd && !done.io) exp_crd = done_val;
    if (e_rd &&  done.io) exp_ird = done_val;
    chk("cpu_rdata", cpu_rdata, exp_crd);
    chk("io_rdata", io_rdata, exp_ird);

    // Advance the model to the next cycle
    done = acc; done_val = '0;
    if (acc.v) begin
      if (acc.a < DEPTH) begin
        if (acc.wr) ref_mem[acc.a] = acc.d;
        else        done_val = ref_mem[acc.a];
      end
    end
    if (e_ig) starve = 0;
    else if (e_cg && i_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
    else if (!acc.v && !i_req) starve = 0;
    acc = '0;
    if (e_cg) acc = '{v: 1'b1, wr: c_w, io: 1'b0, a: c_a, d: c_d};
    if (e_ig) acc = '{v: 1'b1, wr: i_w, io: 1'b1, a: i_a, d: i_d};

    if (e_cg || !c_req) begin
      c_req = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
      new_cmd(c_w, c_a, c_d);
    end
    if (e_ig || !i_req) begin
      i_req = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
      new_cmd(i_w, i_a, i_d);
    end
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) ram[k] = $urandom;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = ram[k];
    model_clear();
    c_w = 1'b0; c_a = '0; c_d = '0; i_w = 1'b0; i_a = '0; i_d = '0;
    drive();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1 chk_all_zero("rst");
    reset = 1'b0;

    repeat (40) step(1);
    repeat (1500) step(0);
    repeat (4) step(2);

    // Reset pulsed during the ACCESS cycle of a CPU read
    c_req = 1'b1; c_w = 1'b0; c_a = AW'(2); c_d = '0;
    step(2);
    @(negedge clock);
    drive();
    reset = 1'b1;
    @(negedge clock);
    #1 chk_all_zero("rst_acc");
    reset = 1'b0;
    model_clear();
    c_req = 1'b1; c_w = 1'b0; c_a = AW'(3); c_d = '0;
    repeat (4) step(2);

    repeat (500) step(0);
    repeat (40) step(1);
    repeat (4) step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
